// File: rtl/demux_route_3bit_pkg.sv
// Shared types and sizing for the 1-to-6 write-back demultiplexer.
// Channel count and select width live here so the top, slots and bench stay in step.
package demux_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned N_OUT  = 6;
  localparam int unsigned SEL_W  = 3;

  typedef logic [SEL_W-1:0]  sel_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic {
    SLOT_EMPTY,
    SLOT_FULL
  } slot_state_t;

  // Selects past the last channel fall back to channel 0, matching the 6:1 read mux.
  function automatic logic sel_legal(sel_t sel);
    return 32'(sel) < N_OUT;
  endfunction

endpackage

// File: rtl/demux_route_3bit_if.sv
// Producer-side handshake plus the per-channel consumer handshakes of the demux.
// The master modport is the environment (producer and consumers), slave is the demux.
interface demux_route_3bit_if;
  import demux_pkg::*;

  logic                    in_valid;
  logic                    in_ready;
  data_t                   in_data;
  sel_t                    in_sel;
  logic [N_OUT-1:0]        out_valid;
  logic [N_OUT-1:0]        out_ready;
  logic [N_OUT*DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/demux_route_3bit_slot.sv
// One output channel: a single-entry holding register with an EMPTY/FULL state.
// A full slot can reload in the same cycle its consumer drains it, so there is no bubble.
module demux_slot
  import demux_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load,
  input  data_t data_in,
  input  logic  out_ready,
  output logic  out_valid,
  output data_t out_data,
  output logic  can_load
);

  slot_state_t state_q, state_d;
  data_t       data_q, data_d;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (load) begin
      state_d = SLOT_FULL;
      data_d  = data_in;
    end else if (state_q == SLOT_FULL && out_ready) begin
      state_d = SLOT_EMPTY;
    end
  end

  // Data is left untouched on drain; consumers qualify it with out_valid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = (state_q == SLOT_FULL);
  assign out_data  = data_q;
  assign can_load  = (state_q == SLOT_EMPTY) | out_ready;

endmodule

// File: rtl/demux_route_3bit.sv
// Registered 1-to-6 demux with valid/ready: routes each word to one holding slot
// and keeps a sticky flag plus a saturating count of illegal selects.
module demux_route_3bit
  import demux_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  demux_route_3bit_if.slave   bus,
  input  logic                err_clr,
  output logic                sel_err,
  output logic [7:0]          err_count
);

  sel_t             tgt;
  logic             sel_ok;
  logic             accept;
  logic [N_OUT-1:0] can_load;
  logic [N_OUT-1:0] load;
  logic [N_OUT-1:0] slot_valid;
  data_t            slot_data [N_OUT];

  logic       sel_err_q, sel_err_d;
  logic [7:0] err_count_q, err_count_d;

  // Ready depends only on the addressed slot, so a stalled channel blocks only its own traffic.
  always_comb begin
    sel_ok       = sel_legal(bus.in_sel);
    tgt          = sel_ok ? bus.in_sel : '0;
    bus.in_ready = reset & can_load[tgt];
    accept       = bus.in_valid & bus.in_ready;
    load         = '0;
    for (int i = 0; i < int'(N_OUT); i++) begin
      load[i] = accept && (int'(tgt) == i);
    end
  end

  for (genvar g = 0; g < int'(N_OUT); g++) begin : g_slot
    demux_slot u_slot (
      .clk       (clk),
      .reset     (reset),
      .load      (load[g]),
      .data_in   (bus.in_data),
      .out_ready (bus.out_ready[g]),
      .out_valid (slot_valid[g]),
      .out_data  (slot_data[g]),
      .can_load  (can_load[g])
    );
  end

  always_comb begin
    bus.out_valid = slot_valid;
    bus.out_data  = '0;
    for (int i = 0; i < int'(N_OUT); i++) begin
      bus.out_data[i*DATA_W +: DATA_W] = slot_data[i];
    end
  end

  // A clear coinciding with an illegal accept counts that accept, leaving a count of one.
  always_comb begin
    sel_err_d   = sel_err_q;
    err_count_d = err_count_q;
    if (err_clr) begin
      sel_err_d   = 1'b0;
      err_count_d = '0;
    end
    if (accept && !sel_ok) begin
      sel_err_d = 1'b1;
      if (err_count_d != 8'hFF) begin
        err_count_d = err_count_d + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sel_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      sel_err_q   <= sel_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign sel_err   = sel_err_q;
  assign err_count = err_count_q;

endmodule
